// File: rtl/gauss11_filter.sv
// gauss11_filter: pipelined 11x11 separable Gaussian blur for the SIFT
// scale-space path. It takes the eleven 88-bit rows from the window generator
// and produces one rounded 8-bit centre pixel per valid window, 4 cycles later.
// It also counts output pixels per frame and pulses frame_done on the last one.
//
// Ports:
//   clk, rst             rising-edge clock, async active-high reset
//   row1..row11 [87:0]   window rows, row1 top; [87:80] = column 1 (left)
//   in_valid, in_sof     window valid / first window of frame
//   dout [7:0]           filtered pixel, holds between valid outputs
//   dout_valid, dout_sof output valid / first output of frame
//   frame_done           pulse with the FRAME_PIX-th output of a frame
//   pix_cnt [15:0]       0-based index of the latest output within the frame
module gauss11_filter #(
  parameter logic [47:0] COEF      = 48'h00_03_0B_1D_35_40, // {C5..C0}, C0 = centre
  parameter logic [15:0] FRAME_PIX = 16'd40000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [87:0] row1,
  input  logic [87:0] row2,
  input  logic [87:0] row3,
  input  logic [87:0] row4,
  input  logic [87:0] row5,
  input  logic [87:0] row6,
  input  logic [87:0] row7,
  input  logic [87:0] row8,
  input  logic [87:0] row9,
  input  logic [87:0] row10,
  input  logic [87:0] row11,
  input  logic        in_valid,
  input  logic        in_sof,
  output logic [7:0]  dout,
  output logic        dout_valid,
  output logic        dout_sof,
  output logic        frame_done,
  output logic [15:0] pix_cnt
);

  logic [87:0] w_rows [11];
  assign w_rows[0]  = row1;
  assign w_rows[1]  = row2;
  assign w_rows[2]  = row3;
  assign w_rows[3]  = row4;
  assign w_rows[4]  = row5;
  assign w_rows[5]  = row6;
  assign w_rows[6]  = row7;
  assign w_rows[7]  = row8;
  assign w_rows[8]  = row9;
  assign w_rows[9]  = row10;
  assign w_rows[10] = row11;

  // Stage valid/sof shift pipeline; index 0 = S1, 2 = S3, S4 is dout_valid.
  logic [2:0] r_vld_pipe;
  logic [2:0] r_sof_pipe;

  // S1: fold symmetric rows so each column needs only 6 multiplies.
  logic [8:0] r_pv [11][6];
  always_ff @(posedge clk) begin
    for (int c = 0; c < 11; c++) begin
      r_pv[c][0] <= {1'b0, w_rows[5][87-8*c -: 8]};
      for (int k = 1; k < 6; k++)
        r_pv[c][k] <= {1'b0, w_rows[5-k][87-8*c -: 8]} + {1'b0, w_rows[5+k][87-8*c -: 8]};
    end
  end

  // S2: vertical MAC per column. Each term and the sum fit in 16 bits.
  logic [15:0] w_col [11];
  logic [15:0] r_col [11];
  always_comb begin
    for (int c = 0; c < 11; c++) begin
      w_col[c] = '0;
      for (int k = 0; k < 6; k++)
        w_col[c] = w_col[c] + ({8'd0, COEF[8*k +: 8]} * {7'd0, r_pv[c][k]});
    end
  end
  always_ff @(posedge clk) r_col <= w_col;

  // S3: horizontal fold + MAC on the column sums.
  logic [16:0] w_ph [6];
  logic [23:0] w_acc;
  logic [23:0] r_acc;
  always_comb begin
    w_ph[0] = {1'b0, r_col[5]};
    for (int k = 1; k < 6; k++)
      w_ph[k] = {1'b0, r_col[5-k]} + {1'b0, r_col[5+k]};
    w_acc = '0;
    for (int k = 0; k < 6; k++)
      w_acc = w_acc + ({16'd0, COEF[8*k +: 8]} * {7'd0, w_ph[k]});
  end
  always_ff @(posedge clk) r_acc <= w_acc;

  // S4: round to nearest (kernel gain is 2^16), saturate as a guard.
  logic [8:0] w_rnd;
  assign w_rnd = 9'(({1'b0, r_acc} + 25'd32768) >> 16);

  // Frame counter next state; sof always restarts the frame.
  logic [15:0] w_cnt_nxt;
  logic        w_done;
  always_comb begin
    if (r_sof_pipe[2])
      w_cnt_nxt = 16'd0;
    else if (pix_cnt == FRAME_PIX - 16'd1)
      w_cnt_nxt = 16'd0;
    else
      w_cnt_nxt = pix_cnt + 16'd1;
    w_done = (w_cnt_nxt == FRAME_PIX - 16'd1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld_pipe <= '0;
      r_sof_pipe <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      dout_sof   <= 1'b0;
      frame_done <= 1'b0;
      pix_cnt    <= '0;
    end else begin
      r_vld_pipe <= {r_vld_pipe[1:0], in_valid};
      r_sof_pipe <= {r_sof_pipe[1:0], in_valid & in_sof};
      dout_valid <= r_vld_pipe[2];
      dout_sof   <= r_vld_pipe[2] & r_sof_pipe[2];
      frame_done <= r_vld_pipe[2] & w_done;
      if (r_vld_pipe[2]) begin
        dout    <= w_rnd[8] ? 8'hFF : w_rnd[7:0];
        pix_cnt <= w_cnt_nxt;
      end
    end
  end

endmodule

// File: tb/tb_gauss11_filter.sv
module tb_gauss11_filter;
  localparam logic [15:0] FP = 16'd8;
  localparam logic [47:0] CF = 48'h00_03_0B_1D_35_40;

  logic        clk = 1'b0;
  logic        rst;
  logic [87:0] row [11];
  logic        in_valid, in_sof;
  logic [7:0]  dout;
  logic        dout_valid, dout_sof, frame_done;
  logic [15:0] pix_cnt;

  gauss11_filter #(.COEF(CF), .FRAME_PIX(FP)) dut (
    .clk(clk), .rst(rst),
    .row1(row[0]), .row2(row[1]), .row3(row[2]), .row4(row[3]),
    .row5(row[4]), .row6(row[5]), .row7(row[6]), .row8(row[7]),
    .row9(row[8]), .row10(row[9]), .row11(row[10]),
    .in_valid(in_valid), .in_sof(in_sof),
    .dout(dout), .dout_valid(dout_valid), .dout_sof(dout_sof),
    .frame_done(frame_done), .pix_cnt(pix_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          due;
    logic [7:0]  d;
    logic        sof;
    logic [15:0] cnt;
    logic        done;
  } exp_t;

  exp_t        sb[$];
  int          n_chk = 0, n_pass = 0, n_fail = 0, n_valid = 0, n_done = 0;
  logic [7:0]  last_dout = 8'd0;
  logic [15:0] m_cnt = 16'd0;
  logic [7:0]  win [11][11];

  // Direct 2-D convolution with weight w[r]*w[c], same round-half-up rule.
  function automatic logic [7:0] model();
    logic [47:0] cf;
    longint      w[11];
    longint      acc, r;
    cf  = CF;
    acc = 0;
    for (int i = 0; i < 11; i++) begin
      int d;
      d    = (i < 5) ? 5 - i : i - 5;
      w[i] = longint'(cf[8*d +: 8]);
    end
    for (int ri = 0; ri < 11; ri++)
      for (int ci = 0; ci < 11; ci++)
        acc += w[ri] * w[ci] * longint'(win[ri][ci]);
    r = (acc + 32768) >> 16;
    return (r > 255) ? 8'hFF : 8'(r);
  endfunction

  task automatic fill(input logic [7:0] v);
    for (int ri = 0; ri < 11; ri++)
      for (int ci = 0; ci < 11; ci++) win[ri][ci] = v;
  endtask

  task automatic rand_win();
    for (int ri = 0; ri < 11; ri++)
      for (int ci = 0; ci < 11; ci++) win[ri][ci] = 8'($urandom_range(0, 255));
  endtask

  // Present the current window for one cycle; scoreboard the expected output.
  task automatic push_drive(input logic v, input logic s);
    exp_t e;
    in_valid = v;
    in_sof   = s;
    for (int ri = 0; ri < 11; ri++)
      for (int ci = 0; ci < 11; ci++) row[ri][87-8*ci -: 8] = win[ri][ci];
    if (v) begin
      if (s) begin
        m_cnt  = 16'd0;
        e.done = (FP == 16'd1);
      end else begin
        m_cnt  = (m_cnt == FP - 16'd1) ? 16'd0 : m_cnt + 16'd1;
        e.done = (m_cnt == FP - 16'd1);
      end
      e.due = cyc + 4;
      e.d   = model();
      e.sof = s;
      e.cnt = m_cnt;
      sb.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) push_drive(1'b0, 1'b0);
  endtask

  // Output monitor: every cycle either the scoreboard head is due or nothing is.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (sb.size() > 0 && sb[0].due == cyc) begin
        exp_t e;
        e = sb.pop_front();
        n_chk++;
        if (dout_valid !== 1'b1 || dout !== e.d || dout_sof !== e.sof ||
            pix_cnt !== e.cnt || frame_done !== e.done) begin
          n_fail++;
          $display("FAIL output@%0d: got v=%b d=%0d sof=%b cnt=%0d done=%b want v=1 d=%0d sof=%b cnt=%0d done=%b",
                   cyc, dout_valid, dout, dout_sof, pix_cnt, frame_done, e.d, e.sof, e.cnt, e.done);
        end else n_pass++;
      end else begin
        n_chk++;
        if (dout_valid !== 1'b0 || dout_sof !== 1'b0 || frame_done !== 1'b0) begin
          n_fail++;
          $display("FAIL idle@%0d: got v=%b sof=%b done=%b want all 0",
                   cyc, dout_valid, dout_sof, frame_done);
        end else n_pass++;
      end
      if (dout_valid === 1'b1) begin
        n_valid++;
        last_dout = dout;
        if (frame_done === 1'b1) n_done++;
      end
    end
  end

  task automatic check_zero_outs(input string nm);
    n_chk++;
    if (dout !== 8'd0 || dout_valid !== 1'b0 || dout_sof !== 1'b0 ||
        frame_done !== 1'b0 || pix_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL %s: got d=%0d v=%b sof=%b done=%b cnt=%0d want all 0",
               nm, dout, dout_valid, dout_sof, frame_done, pix_cnt);
    end else n_pass++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check_zero_outs("reset_values");
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_uniform();
    int nv;
    fill(8'd100);
    nv = n_valid;
    push_drive(1'b1, 1'b0);
    idle(6);
    #1;
    n_chk++;
    if (n_valid - nv !== 1 || last_dout !== 8'd100) begin
      n_fail++;
      $display("FAIL uniform100: got outs=%0d d=%0d want outs=1 d=100", n_valid - nv, last_dout);
    end else n_pass++;
  endtask

  task automatic test_impulse();
    fill(8'd0);
    win[5][5] = 8'd255;
    push_drive(1'b1, 1'b0);
    idle(5);
    #1;
    n_chk++;
    if (last_dout !== 8'd16) begin
      n_fail++;
      $display("FAIL impulse_centre: got %0d want 16", last_dout);
    end else n_pass++;
    fill(8'd0);
    win[0][0] = 8'd255;
    push_drive(1'b1, 1'b0);
    idle(5);
    #1;
    n_chk++;
    if (last_dout !== 8'd0) begin
      n_fail++;
      $display("FAIL impulse_corner: got %0d want 0", last_dout);
    end else n_pass++;
  endtask

  task automatic test_back_to_back();
    int nv;
    fill(8'd255);
    nv = n_valid;
    repeat (20) push_drive(1'b1, 1'b0);
    idle(5);
    #1;
    n_chk++;
    if (n_valid - nv !== 20 || last_dout !== 8'd255) begin
      n_fail++;
      $display("FAIL sat255_burst: got outs=%0d d=%0d want outs=20 d=255", n_valid - nv, last_dout);
    end else n_pass++;
  endtask

  task automatic test_frame();
    int nd;
    nd = n_done;
    for (int i = 0; i < 8; i++) begin
      rand_win();
      push_drive(1'b1, i == 0);
      idle($urandom_range(1, 3));
    end
    idle(4);
    #1;
    n_chk++;
    if (n_done - nd !== 1 || pix_cnt !== 16'd7) begin
      n_fail++;
      $display("FAIL frame8: got done=%0d cnt=%0d want done=1 cnt=7", n_done - nd, pix_cnt);
    end else n_pass++;
    rand_win();
    push_drive(1'b1, 1'b0);
    idle(5);
    #1;
    n_chk++;
    if (n_done - nd !== 1 || pix_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL frame_wrap: got done=%0d cnt=%0d want done=1 cnt=0", n_done - nd, pix_cnt);
    end else n_pass++;
  endtask

  task automatic test_flush();
    int nv;
    nv = n_valid;
    repeat (3) begin
      rand_win();
      push_drive(1'b1, 1'b0);
    end
    in_valid = 1'b0;
    rst      = 1'b1;
    #1;
    check_zero_outs("flush_reset");
    sb.delete();
    m_cnt = 16'd0;
    @(negedge clk);
    rst = 1'b0;
    idle(6);
    #1;
    n_chk++;
    if (n_valid !== nv) begin
      n_fail++;
      $display("FAIL flush_leak: got outs=%0d want 0", n_valid - nv);
    end else n_pass++;
    rand_win();
    push_drive(1'b1, 1'b0);
    idle(5);
    #1;
    n_chk++;
    if (n_valid - nv !== 1) begin
      n_fail++;
      $display("FAIL post_flush: got outs=%0d want 1", n_valid - nv);
    end else n_pass++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 1000; i++) begin
      rand_win();
      push_drive(1'($urandom_range(0, 1)), $urandom_range(0, 9) == 0);
    end
    idle(8);
    #1;
    n_chk++;
    if (sb.size() !== 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending want 0", sb.size());
    end else n_pass++;
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
    for (int ri = 0; ri < 11; ri++) row[ri] = '0;
    fill(8'd0);
    test_reset();
    test_uniform();
    test_impulse();
    test_back_to_back();
    test_frame();
    test_flush();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
